// File: rtl/hqm_aw_wrand_arb_wc_pipe_pkg.sv
// rtl/hqm_aw_wrand_arb_wc_pipe_pkg.sv - shared types and helper functions for the weighted-random arbiter
package hqm_aw_wrand_arb_wc_pipe_pkg;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_RANGE = 2'd1,
      SRC_RR    = 2'd2
   } grant_src_e;

   // floor(log2(value)), 0 for value <= 1
   function automatic int aw_logb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 1) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Right-shifting Galois masks for maximal-length sequences, one per width
   function automatic logic [31:0] aw_lfsr_taps(input int rw);
      logic [31:0] t;
      case (rw)
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0829;
         13:      t = 32'h0000_100D;
         14:      t = 32'h0000_2015;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_D008;
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         19:      t = 32'h0004_0023;
         20:      t = 32'h0009_0000;
         21:      t = 32'h0014_0000;
         22:      t = 32'h0030_0000;
         23:      t = 32'h0042_0000;
         24:      t = 32'h00E1_0000;
         25:      t = 32'h0120_0000;
         26:      t = 32'h0200_0023;
         27:      t = 32'h0400_0013;
         28:      t = 32'h0900_0000;
         29:      t = 32'h1400_0000;
         30:      t = 32'h2000_0029;
         31:      t = 32'h4800_0000;
         32:      t = 32'h8020_0003;
         default: t = 32'h0000_0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hqm_aw_wrand_arb_wc_pipe_lfsr_wupdate.sv
// rtl/hqm_aw_wrand_arb_wc_pipe_lfsr_wupdate.sv - Galois LFSR that steps only when update is set
module hqm_aw_wrand_arb_wc_pipe_lfsr_wupdate
   import hqm_aw_wrand_arb_wc_pipe_pkg::*;
#(
   parameter int          RW   = 16,
   parameter int unsigned SEED = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          update,
   output logic [RW-1:0] lfsr
);

   localparam logic [RW-1:0] TAPS   = RW'(aw_lfsr_taps(RW));
   localparam logic [RW-1:0] SEED_V = RW'(SEED);

   if (SEED_V == '0) begin : g_bad_seed
      $error("LFSR seed must be non-zero");
   end

   logic [RW-1:0] lfsr_q;
   logic [RW-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (update) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED_V;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/hqm_aw_wrand_arb_wc_pipe.sv
// rtl/hqm_aw_wrand_arb_wc_pipe.sv - weighted-random range arbiter with round-robin work-conserving fallback
module hqm_aw_wrand_arb_wc_pipe
   import hqm_aw_wrand_arb_wc_pipe_pkg::*;
#(
   parameter int          NUM_REQS   = 4,
   parameter int          RW         = 16,
   parameter int unsigned SEED       = 1,
   parameter int          NUM_REQSB2 = aw_logb2(NUM_REQS-1) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQS-1:0]    reqs,
   input  logic [NUM_REQS*RW-1:0] cfg_range_min,
   input  logic [NUM_REQS*RW-1:0] cfg_range_max,
   input  logic                   cfg_wc_mode,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [NUM_REQSB2-1:0]  out_winner,
   output logic                   out_configured,
   output logic                   out_fallback
);

   if ((NUM_REQS < 2) || (NUM_REQS > 2048)) begin : g_bad_num_reqs
      $error("NUM_REQS out of range 2..2048");
   end
   if ((RW < 8) || (RW > 32)) begin : g_bad_rw
      $error("RW out of range 8..32");
   end

   logic [RW-1:0]         lfsr;
   logic [RW-1:0]         rnd;
   logic                  load;
   logic                  sample;
   logic [NUM_REQSB2-1:0] hit_idx;
   logic                  hit_req;
   logic [NUM_REQSB2-1:0] rr_idx;
   logic                  rr_found;
   int                    rr_pos;
   grant_src_e            src;

   logic                  out_valid_q, out_valid_d;
   logic [NUM_REQSB2-1:0] out_winner_q, out_winner_d;
   logic                  out_configured_q, out_configured_d;
   logic                  out_fallback_q, out_fallback_d;
   logic [NUM_REQSB2-1:0] rr_ptr_q, rr_ptr_d;

   hqm_aw_wrand_arb_wc_pipe_lfsr_wupdate #(
      .RW   (RW),
      .SEED (SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .update (sample),
      .lfsr   (lfsr)
   );

   // Descending scan so the lowest matching slot is the one left standing
   always_comb begin
      rnd     = lfsr - RW'(1);
      hit_idx = '0;
      hit_req = 1'b0;
      for (int i = NUM_REQS-1; i >= 0; i--) begin
         if ((cfg_range_min[i*RW +: RW] <= rnd) && (rnd <= cfg_range_max[i*RW +: RW])) begin
            hit_idx = NUM_REQSB2'(i);
            hit_req = reqs[i];
         end
      end
   end

   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_pos   = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         rr_pos = int'(rr_ptr_q) + k;
         if (rr_pos >= NUM_REQS) begin
            rr_pos = rr_pos - NUM_REQS;
         end
         if (!rr_found && reqs[rr_pos[NUM_REQSB2-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = rr_pos[NUM_REQSB2-1:0];
         end
      end
   end

   always_comb begin
      load             = ~out_valid_q | out_ready;
      sample           = load & (|reqs);
      out_valid_d      = out_valid_q;
      out_winner_d     = out_winner_q;
      out_configured_d = out_configured_q;
      out_fallback_d   = out_fallback_q;
      rr_ptr_d         = rr_ptr_q;
      src              = SRC_NONE;
      if (hit_req) begin
         src = SRC_RANGE;
      end else if (cfg_wc_mode) begin
         src = SRC_RR;
      end
      if (load) begin
         out_valid_d      = 1'b0;
         out_winner_d     = '0;
         out_configured_d = 1'b0;
         out_fallback_d   = 1'b0;
         if (sample) begin
            case (src)
               SRC_RANGE: begin
                  out_valid_d      = 1'b1;
                  out_winner_d     = hit_idx;
                  out_configured_d = 1'b1;
               end
               SRC_RR: begin
                  out_valid_d    = 1'b1;
                  out_winner_d   = rr_idx;
                  out_fallback_d = 1'b1;
                  rr_ptr_d       = (rr_idx == NUM_REQSB2'(NUM_REQS-1)) ? '0 : rr_idx + NUM_REQSB2'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q      <= 1'b0;
         out_winner_q     <= '0;
         out_configured_q <= 1'b0;
         out_fallback_q   <= 1'b0;
         rr_ptr_q         <= '0;
      end else begin
         out_valid_q      <= out_valid_d;
         out_winner_q     <= out_winner_d;
         out_configured_q <= out_configured_d;
         out_fallback_q   <= out_fallback_d;
         rr_ptr_q         <= rr_ptr_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_winner     = out_winner_q;
   assign out_configured = out_configured_q;
   assign out_fallback   = out_fallback_q;

`ifndef INTEL_SVA_OFF
   logic cfg_overlap;

   // Only configured slots (max >= min) can overlap
   always_comb begin
      cfg_overlap = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         for (int j = i + 1; j < NUM_REQS; j++) begin
            if ((cfg_range_max[i*RW +: RW] >= cfg_range_min[i*RW +: RW]) &&
                (cfg_range_max[j*RW +: RW] >= cfg_range_min[j*RW +: RW]) &&
                (cfg_range_min[i*RW +: RW] <= cfg_range_max[j*RW +: RW]) &&
                (cfg_range_min[j*RW +: RW] <= cfg_range_max[i*RW +: RW])) begin
               cfg_overlap = 1'b1;
            end
         end
      end
   end

   a_no_range_overlap: assert property (@(posedge clk) disable iff (rst) !(cfg_overlap && (|reqs)));
`endif

endmodule

// File: tb/tb_hqm_aw_wrand_arb_wc_pipe.sv
// tb/tb_hqm_aw_wrand_arb_wc_pipe.sv - scoreboard bench for the weighted-random arbiter
module tb_hqm_aw_wrand_arb_wc_pipe;

   localparam int NR = 4;
   localparam int RW = 16;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   reqs;
   logic [NR*RW-1:0] cfg_range_min;
   logic [NR*RW-1:0] cfg_range_max;
   logic            cfg_wc_mode;
   logic            out_ready;
   logic            out_valid;
   logic [1:0]      out_winner;
   logic            out_configured;
   logic            out_fallback;

   hqm_aw_wrand_arb_wc_pipe #(
      .NUM_REQS (NR),
      .RW       (RW),
      .SEED     (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .reqs           (reqs),
      .cfg_range_min  (cfg_range_min),
      .cfg_range_max  (cfg_range_max),
      .cfg_wc_mode    (cfg_wc_mode),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_winner     (out_winner),
      .out_configured (out_configured),
      .out_fallback   (out_fallback)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  w;
      logic        c;
      logic        f;
      logic [15:0] l;
   } exp_t;

   exp_t        sb[$];
   int          n_chk;
   int          n_err;
   int          mn[NR];
   int          mx[NR];
   logic [15:0] m_lfsr;
   int          m_rr;
   logic        m_v;
   int          m_w;
   logic        m_c;
   logic        m_f;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_slot(input int i, input int lo, input int hi);
      mn[i] = lo;
      mx[i] = hi;
      cfg_range_min[i*RW +: RW] = 16'(lo);
      cfg_range_max[i*RW +: RW] = 16'(hi);
   endtask

   task automatic cfg_unconfigured();
      for (int i = 0; i < NR; i++) set_slot(i, 16'hFFFF, 0);
   endtask

   task automatic cfg_dist(input int top3);
      set_slot(0, 16'h0000, 16'h3FFF);
      set_slot(1, 16'h4000, 16'h7FFF);
      set_slot(2, 16'h8000, 16'h9FFF);
      set_slot(3, 16'hA000, top3);
   endtask

   // Model: advance one clock given this cycle's inputs, then compare after the edge
   task automatic step(input logic [3:0] r, input logic rdy);
      exp_t e;
      reqs      = r;
      out_ready = rdy;
      if (rst) begin
         m_lfsr = 16'h0001;
         m_rr   = 0;
         m_v    = 1'b0;
         m_w    = 0;
         m_c    = 1'b0;
         m_f    = 1'b0;
      end else if (!m_v || rdy) begin
         m_v = 1'b0;
         m_w = 0;
         m_c = 1'b0;
         m_f = 1'b0;
         if (r != 4'd0) begin
            int rnd;
            int hit;
            int pos;
            rnd = int'(m_lfsr) - 1;
            hit = -1;
            for (int i = 0; i < NR; i++) begin
               if (hit < 0 && mn[i] <= rnd && rnd <= mx[i]) hit = i;
            end
            if (hit >= 0 && r[hit]) begin
               m_v = 1'b1;
               m_w = hit;
               m_c = 1'b1;
            end else if (cfg_wc_mode) begin
               pos = m_rr;
               while (!r[pos]) pos = (pos + 1) % NR;
               m_v  = 1'b1;
               m_w  = pos;
               m_f  = 1'b1;
               m_rr = (pos + 1) % NR;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hD008) : (m_lfsr >> 1);
         end
      end
      e.v = m_v;
      e.w = 2'(m_w);
      e.c = m_c;
      e.f = m_f;
      e.l = m_lfsr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("valid", 64'(out_valid), 64'(e.v));
      if (e.v) begin
         chk("winner", 64'(out_winner), 64'(e.w));
         chk("configured", 64'(out_configured), 64'(e.c));
         chk("fallback", 64'(out_fallback), 64'(e.f));
      end
      chk("lfsr", 64'(dut.u_lfsr.lfsr), 64'(e.l));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int good;
      int prev;
      int nval;
      int cnt[NR];
      int nog;

      n_chk         = 0;
      n_err         = 0;
      rst           = 1'b1;
      reqs          = '0;
      out_ready     = 1'b1;
      cfg_wc_mode   = 1'b1;
      cfg_range_min = '0;
      cfg_range_max = '0;
      cfg_dist(16'hFFEF);

      // Reset and first grant
      repeat (2) begin
         step(4'hF, 1'b1);
         chk("t1_rst_valid", 64'(out_valid), 64'd0);
         chk("t1_rst_winner", 64'(out_winner), 64'd0);
      end
      rst = 1'b0;
      chk("t1_rel_valid", 64'(out_valid), 64'd0);
      chk("t1_rel_winner", 64'(out_winner), 64'd0);
      step(4'hF, 1'b1);
      chk("t1_first_grant", 64'(out_valid), 64'd1);

      // Single slot covering the whole random range
      cfg_unconfigured();
      set_slot(1, 16'h0000, 16'hFFFE);
      cfg_wc_mode = 1'b0;
      good = 0;
      repeat (1000) begin
         step(4'b0010, 1'b1);
         if (out_valid && out_winner == 2'd1 && out_configured) good++;
      end
      chk("t2_good_cycles", 64'(good), 64'd1000);

      // Pure round-robin fallback, then no fallback
      cfg_unconfigured();
      cfg_wc_mode = 1'b1;
      prev = -1;
      repeat (20) begin
         step(4'b1010, 1'b1);
         chk("t3_flags", 64'({out_valid, out_fallback, out_configured}), 64'(3'b110));
         chk("t3_odd_winner", 64'(out_winner == 2'd1 || out_winner == 2'd3), 64'd1);
         if (prev >= 0) chk("t3_alternate", 64'(int'(out_winner) != prev), 64'd1);
         prev = int'(out_winner);
      end
      cfg_wc_mode = 1'b0;
      nval = 0;
      repeat (20) begin
         step(4'b1010, 1'b1);
         if (out_valid) nval++;
      end
      chk("t3_no_wc_grants", 64'(nval), 64'd0);

      // Backpressure: inputs and config move while the winner is held
      cfg_dist(16'hFFEF);
      cfg_wc_mode = 1'b1;
      step(4'hF, 1'b1);
      chk("t4_grant", 64'(out_valid), 64'd1);
      cfg_unconfigured();
      repeat (5) step(4'($urandom_range(0, 15)), 1'b0);
      cfg_dist(16'hFFEF);
      repeat (20) step(4'($urandom_range(0, 15)), 1'b1);

      // Distribution over a full LFSR period
      cfg_wc_mode = 1'b0;
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      nog = 0;
      repeat (65535) begin
         step(4'hF, 1'b1);
         if (out_valid && out_configured) cnt[out_winner]++;
         else if (!out_valid) nog++;
      end
      chk("t5_cnt0", 64'(cnt[0]), 64'h4000);
      chk("t5_cnt1", 64'(cnt[1]), 64'h4000);
      chk("t5_cnt2", 64'(cnt[2]), 64'h2000);
      chk("t5_cnt3", 64'(cnt[3]), 64'h5FF0);
      chk("t5_no_grant", 64'(nog), 64'd15);

      // Mixed traffic against the model, including reset over a held winner
      cfg_dist(16'hBFFF);
      for (int n = 0; n < 1500; n++) begin
         if (n % 100 == 0) cfg_wc_mode = ~cfg_wc_mode;
         rst = (n == 700);
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      end
      rst = 1'b0;
      step(4'h0, 1'b1);
      chk("t6_idle", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
